// File: rtl/fp_sqrt_pkg.sv
// Shared types and constants for the FP_SQRT sequencer and its special-operand classifier.
package fp_sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fp_sqrt_sequencer_if.sv
// Operand and result valid/ready streams of the FP_SQRT sequencer.
interface fp_sqrt_sequencer_if #(
  parameter int DATAWIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fp_special_detect.sv
// Combinational IEEE-754 single classifier for operands whose square root needs no core.
// Only built when SQRT_SPECIAL_BYPASS_EN is defined, the only configuration that uses it.
`ifdef SQRT_SPECIAL_BYPASS_EN
module fp_special_detect
  import fp_sqrt_pkg::*;
(
  input  logic [31:0] operand,
  output logic        is_special,
  output logic [31:0] special_result
);

  logic             sign;
  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             is_zero;
  logic             is_nan;
  logic             is_inf;

  assign {sign, exp_f, man_f} = operand;
  assign is_zero = (exp_f == '0) && (man_f == '0);
  assign is_nan  = (exp_f == '1) && (man_f != '0);
  assign is_inf  = (exp_f == '1) && (man_f == '0);

  // Signed zero must come before the negative test so -0 keeps its sign.
  always_comb begin
    is_special     = 1'b1;
    special_result = '0;
    if (is_zero) begin
      special_result = operand;
    end else if (is_nan || sign) begin
      special_result = QNAN;
    end else if (is_inf) begin
      special_result = POS_INF;
    end else begin
      is_special = 1'b0;
    end
  end

endmodule
`endif

// File: rtl/fp_sqrt_sequencer.sv
// Control stage that drives the FP_SQRT core start/latency timing between two valid/ready streams.
// Define SQRT_SPECIAL_BYPASS_EN to resolve NaN/negative/zero/+Inf operands without starting the core.
module fp_sqrt_sequencer
  import fp_sqrt_pkg::*;
#(
  parameter int DATAWIDTH    = 32,
  parameter int START_CYCLES = 3,
  parameter int LATENCY      = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_sqrt_sequencer_if.slave   bus,
  output logic                 core_start,
  output logic [DATAWIDTH-1:0] core_data_i,
  input  logic [DATAWIDTH-1:0] core_data_o,
  output logic                 busy
);

  localparam int CNT_W = $clog2(max_int(START_CYCLES, LATENCY) + 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(LATENCY);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic                 is_special;
  logic [DATAWIDTH-1:0] special_result;

`ifdef SQRT_SPECIAL_BYPASS_EN
  fp_special_detect u_special_detect (
    .operand        (bus.in_data),
    .is_special     (is_special),
    .special_result (special_result)
  );
`else
  assign is_special     = 1'b0;
  assign special_result = '0;
`endif

  assign bus.in_ready = (state == IDLE);
  assign busy         = (state != IDLE);

  // A bypassed operand enters HOLD with out_valid low; it rises on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      core_start    <= 1'b0;
      core_data_i   <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            cnt <= '0;
            if (is_special) begin
              bus.out_data <= special_result;
              state        <= HOLD;
            end else begin
              core_data_i <= bus.in_data;
              core_start  <= 1'b1;
              state       <= START;
            end
          end
        end
        START: begin
          if (cnt == START_LAST) begin
            core_start <= 1'b0;
            cnt        <= '0;
            state      <= WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (cnt == WAIT_LAST) begin
            bus.out_data  <= core_data_o;
            bus.out_valid <= 1'b1;
            cnt           <= '0;
            state         <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (!bus.out_valid) begin
            bus.out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sqrt_sequencer.sv
// Self-checking bench for fp_sqrt_sequencer with a behavioural FP_SQRT core stand-in.
module tb_fp_sqrt_sequencer;
  import fp_sqrt_pkg::*;

  localparam int DW       = 32;
  localparam int SC       = 3;
  localparam int LAT      = 50;
  localparam int FULL_LAT = SC + LAT + 1;
`ifdef SQRT_SPECIAL_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [31:0] op;
    logic [31:0] res;
    bit          special;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_start;
  logic [DW-1:0] core_data_i;
  logic [DW-1:0] core_data_o;
  logic          busy;

  int tests = 0;
  int fails = 0;

  fp_sqrt_sequencer_if #(.DATAWIDTH(DW)) bus ();

  fp_sqrt_sequencer #(
    .DATAWIDTH    (DW),
    .START_CYCLES (SC),
    .LATENCY      (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .core_start  (core_start),
    .core_data_i (core_data_i),
    .core_data_o (core_data_o),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Correctly rounded single-precision sqrt via double arithmetic.
  function automatic logic [31:0] sqrt_ref(input logic [31:0] x);
    logic [7:0]  e;
    logic [22:0] m;
    logic [63:0] b;
    logic [31:0] res;
    real         r;
    int          se;
    e = x[30:23];
    m = x[22:0];
    if (e == 8'hFF && m != 23'd0) return QNAN;
    if (e == 8'h00 && m == 23'd0) return x;
    if (x[31]) return QNAN;
    if (e == 8'hFF) return POS_INF;
    if (e == 8'h00) begin
      r = real'(m);
      repeat (149) r = r / 2.0;
    end else begin
      r = $bitstoreal({1'b0, 11'(int'(e) + 896), m, 29'b0});
    end
    r   = $sqrt(r);
    b   = $realtobits(r);
    se  = int'(b[62:52]) - 896;
    res = {1'b0, 8'(se), b[51:29]};
    if (b[28] && ((|b[27:0]) || b[29])) res = res + 32'd1;
    return res;
  endfunction

  // Core stand-in: result appears only LAT cycles after start falls, garbage otherwise.
  logic [31:0] core_op;
  int          core_cnt;
  logic        core_armed;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_armed <= 1'b0;
      core_cnt   <= 0;
      core_op    <= 32'd0;
    end else if (core_start) begin
      core_armed <= 1'b1;
      core_cnt   <= 0;
      core_op    <= core_data_i;
    end else if (core_armed && core_cnt < 1000) begin
      core_cnt <= core_cnt + 1;
    end
  end

  always_comb begin
    core_data_o = 32'hDEADBEEF;
    if (core_armed && !core_start && core_cnt >= LAT) core_data_o = sqrt_ref(core_op);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Hands one operand over and waits for out_valid, recording latency and start width.
  task automatic applyStimulus(input logic [31:0] op, output int lat, output int starts,
                               output logic [31:0] cdi, output logic [31:0] prev);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) checkOutput("in_ready_wait", 32'd0, 32'd1);
    prev         = core_data_i;
    bus.in_valid = 1'b1;
    bus.in_data  = op;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    cdi    = core_data_i;
    lat    = 0;
    starts = 0;
    while (!bus.out_valid && lat < 300) begin
      if (core_start) starts++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runCheck(input string name, input logic [31:0] op, input logic [31:0] expv, input bit special);
    int          lat;
    int          starts;
    logic [31:0] cdi;
    logic [31:0] prev;
    bit          byp;
    byp = BYPASS && special;
    applyStimulus(op, lat, starts, cdi, prev);
    checkOutput({name, "_data"}, bus.out_data, expv);
    checkOutput({name, "_latency"}, 32'(lat), byp ? 32'd1 : 32'(FULL_LAT));
    checkOutput({name, "_start_cycles"}, 32'(starts), byp ? 32'd0 : 32'(SC));
    checkOutput({name, "_core_data_i"}, cdi, byp ? prev : op);
    @(negedge clk);
    checkOutput({name, "_release"}, {30'b0, bus.out_valid, bus.in_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs[10];
    logic [31:0] b2b_ops[4];
    logic [31:0] got[$];
    int          acc_cyc[$];
    int          xf_cyc[$];
    int          lat;
    int          starts;
    int          idx;
    logic [31:0] cdi;
    logic [31:0] prev;
    logic [31:0] rop;
    bit          stable;
    bit          acc;
    bit          xf;

    vecs[0] = '{32'h40800000, 32'h40000000, 1'b0};
    vecs[1] = '{32'h40000000, 32'h3FB504F3, 1'b0};
    vecs[2] = '{32'h3E800000, 32'h3F000000, 1'b0};
    vecs[3] = '{32'h3F800000, 32'h3F800000, 1'b0};
    vecs[4] = '{32'h42C80000, 32'h41200000, 1'b0};
    vecs[5] = '{32'hBF800000, 32'h7FC00000, 1'b1};
    vecs[6] = '{32'h80000000, 32'h80000000, 1'b1};
    vecs[7] = '{32'h7F800000, 32'h7F800000, 1'b1};
    vecs[8] = '{32'h00000000, 32'h00000000, 1'b1};
    vecs[9] = '{32'h7FC00001, 32'h7FC00000, 1'b1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.out_ready = 1'b1;
    #2;
    checkOutput("reset_flags", {28'b0, core_start, bus.out_valid, busy, bus.in_ready}, 32'd1);
    checkOutput("reset_core_data_i", core_data_i, 32'd0);
    checkOutput("reset_out_data", bus.out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) runCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].res, vecs[i].special);

    for (int i = 0; i < 8; i++) begin
      rop = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      runCheck($sformatf("rand%0d", i), rop, sqrt_ref(rop), 1'b0);
    end

    // Backpressure: result must sit still for 20 cycles, then transfer once.
    bus.out_ready = 1'b0;
    applyStimulus(32'h40800000, lat, starts, cdi, prev);
    checkOutput("bp_data", bus.out_data, 32'h40000000);
    checkOutput("bp_latency", 32'(lat), 32'(FULL_LAT));
    stable = 1'b1;
    repeat (20) begin
      if (!(bus.out_valid && bus.out_data == 32'h40000000 && !bus.in_ready && busy)) stable = 1'b0;
      @(negedge clk);
    end
    checkOutput("bp_stable", {31'b0, stable}, 32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release", {30'b0, bus.out_valid, bus.in_ready}, 32'd1);

    // Reset while core_start is high must drop it without a clock edge.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h40800000;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("rst_start_pre", {31'b0, core_start}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_start_flags", {28'b0, core_start, bus.out_valid, busy, bus.in_ready}, 32'd1);
    #1;
    rst = 1'b0;

    // Reset in cycle 10 of the wait, then a fresh operand must run normally.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h40000000;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (SC + 10) @(negedge clk);
    checkOutput("rst_wait_pre", {30'b0, busy, core_start}, 32'd2);
    rst = 1'b1;
    #1;
    checkOutput("rst_wait_flags", {28'b0, core_start, bus.out_valid, busy, bus.in_ready}, 32'd1);
    #1;
    rst = 1'b0;
    runCheck("after_reset", 32'h41100000, 32'h40400000, 1'b0);

    // Back-to-back: in_valid stays high across four operands.
    b2b_ops[0] = 32'h41100000;
    b2b_ops[1] = 32'h40800000;
    b2b_ops[2] = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
    b2b_ops[3] = 32'h3E800000;
    @(negedge clk);
    idx          = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b2b_ops[0];
    for (int cyc = 0; cyc < 2000 && got.size() < 4; cyc++) begin
      acc = bus.in_valid && bus.in_ready;
      xf  = bus.out_valid && bus.out_ready;
      if (xf) begin
        got.push_back(bus.out_data);
        xf_cyc.push_back(cyc);
      end
      if (acc) acc_cyc.push_back(cyc);
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 4) bus.in_data = b2b_ops[idx];
        else bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("b2b_result%0d", i), (i < got.size()) ? got[i] : 32'hFFFFFFFF,
                  sqrt_ref(b2b_ops[i]));
    end
    for (int i = 1; i < 4; i++) begin
      checkOutput($sformatf("b2b_gap%0d", i),
                  (i < acc_cyc.size() && i - 1 < xf_cyc.size()) ? 32'(acc_cyc[i] - xf_cyc[i-1]) : 32'hFFFFFFFF,
                  32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
